// File: rtl/jtframe_sdram_pkg.sv
// Shared constants for the SDRAM request arbiter: FSM encoding and address width.
package jtframe_sdram_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_RDY  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

endpackage

// File: rtl/jtframe_rq_arb_if.sv
// Bundle of slot-side and controller-side signals around jtframe_rq_arb.
interface jtframe_rq_arb_if
  import jtframe_sdram_pkg::*;
#(
  parameter int DW = 16
) ();

  // Slots hold slotN_req as a level until they observe their slotN_we;
  // sdram_req stays high until sdram_ack, and sdram_rdy completes the transfer.
  logic                slot0_req,    slot1_req;
  logic                slot0_rnw,    slot1_rnw;
  logic [SDRAM_AW-1:0] slot0_addr,   slot1_addr;
  logic [DW-1:0]       slot0_wrdata, slot1_wrdata;
  logic                slot0_we,     slot1_we;
  logic [31:0]         din;
  logic                din_ok;
  logic                sdram_req;
  logic                sdram_rnw;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic [DW-1:0]       sdram_din;
  logic                sdram_ack;
  logic                sdram_rdy;
  logic [31:0]         sdram_dout;
  logic                timeout;
  state_t              dbg_state;

  modport master (
    input  slot0_req, slot1_req, slot0_rnw, slot1_rnw,
    input  slot0_addr, slot1_addr, slot0_wrdata, slot1_wrdata,
    input  sdram_ack, sdram_rdy, sdram_dout,
    output slot0_we, slot1_we, din, din_ok,
    output sdram_req, sdram_rnw, sdram_addr, sdram_din,
    output timeout, dbg_state
  );

  modport slave (
    output slot0_req, slot1_req, slot0_rnw, slot1_rnw,
    output slot0_addr, slot1_addr, slot0_wrdata, slot1_wrdata,
    output sdram_ack, sdram_rdy, sdram_dout,
    input  slot0_we, slot1_we, din, din_ok,
    input  sdram_req, sdram_rnw, sdram_addr, sdram_din,
    input  timeout, dbg_state
  );

endinterface

// File: rtl/jtframe_rq_wdog.sv
// Loadable 8-bit down-counter; expire is high while enabled and the count has reached zero.
module jtframe_rq_wdog #(
  parameter int TOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LIMIT;
    end else if (en && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == 8'd0);

endmodule

// File: rtl/jtframe_rq_arb.sv
// Two-slot round-robin arbiter in front of the SDRAM controller command port,
// with shared read-data return and a per-transfer watchdog.
module jtframe_rq_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  jtframe_rq_arb_if.master bus
);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                sel_q, sel_d;
  logic                we0_q, we0_d;
  logic                we1_q, we1_d;
  logic                req_q, req_d;
  logic                rnw_q, rnw_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [31:0]         din_q, din_d;
  logic                din_ok_q, din_ok_d;
  logic                timeout_q, timeout_d;

  logic any_req, pick, done, wdog_load, wdog_en, expire;

  assign any_req   = bus.slot0_req | bus.slot1_req;
  // Contention goes to the slot that was not served last.
  assign pick      = (bus.slot0_req & bus.slot1_req) ? ~last_q : bus.slot1_req;
  assign done      = (state_q == ST_ACK && bus.sdram_ack && bus.sdram_rdy) ||
                     (state_q == ST_RDY && bus.sdram_rdy);
  assign wdog_load = (state_q == ST_IDLE) && any_req;
  assign wdog_en   = (state_q == ST_ACK) || (state_q == ST_RDY);

  jtframe_rq_wdog #(.TOUT(TOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wdog_load),
    .en     (wdog_en),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      we0_q     <= 1'b0;
      we1_q     <= 1'b0;
      req_q     <= 1'b0;
      rnw_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      din_q     <= 32'd0;
      din_ok_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      we0_q     <= we0_d;
      we1_q     <= we1_d;
      req_q     <= req_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      din_q     <= din_d;
      din_ok_q  <= din_ok_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_ACK;
      ST_ACK: begin
        if (done || expire)     state_d = ST_REL;
        else if (bus.sdram_ack) state_d = ST_RDY;
      end
      ST_RDY:  if (done || expire) state_d = ST_REL;
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    sel_d     = sel_q;
    we0_d     = we0_q;
    we1_d     = we1_q;
    req_d     = req_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    din_d     = din_q;
    din_ok_d  = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d   = pick;
          we0_d   = ~pick;
          we1_d   = pick;
          req_d   = 1'b1;
          rnw_d   = pick ? bus.slot1_rnw    : bus.slot0_rnw;
          addr_d  = pick ? bus.slot1_addr   : bus.slot0_addr;
          wdata_d = pick ? bus.slot1_wrdata : bus.slot0_wrdata;
        end
      end
      ST_ACK, ST_RDY: begin
        // A real completion on the expiry cycle still wins over the watchdog.
        if (done) begin
          req_d    = 1'b0;
          din_d    = bus.sdram_dout;
          din_ok_d = 1'b1;
        end else if (expire) begin
          req_d     = 1'b0;
          din_d     = 32'hFFFF_FFFF;
          din_ok_d  = 1'b1;
          timeout_d = 1'b1;
        end else if (state_q == ST_ACK && bus.sdram_ack) begin
          req_d = 1'b0;
        end
      end
      ST_REL: begin
        we0_d  = 1'b0;
        we1_d  = 1'b0;
        last_d = sel_q;
      end
      default: ;
    endcase
  end

  assign bus.slot0_we   = we0_q;
  assign bus.slot1_we   = we1_q;
  assign bus.din        = din_q;
  assign bus.din_ok     = din_ok_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_rnw  = rnw_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_din  = wdata_q;
  assign bus.timeout    = timeout_q;
  assign bus.dbg_state  = state_q;

endmodule
